// File: rtl/mm_psum_accumulator.sv
// mm_psum_accumulator
// Sums the partial-sum stream of every K-slice of one output tile into a local
// buffer, saturating at ACC_W bits, then streams the finished tile downstream.
// Optional build macro: PSUM_SPIKE_EN -- when defined, each drained element is
// replaced by a single spike bit (accumulated value >= SPIKE_THRESH, signed).
//
// state | meaning
// IDLE  | waiting for i_tile_start, nothing accepted or emitted
// ACCUM | accepting partial sums, read-modify-write into tileBuf
// DRAIN | streaming tileBuf[rdIdx] out under out_ready backpressure
module mm_psum_accumulator #(
    parameter int TILE_ROWS    = 16,
    parameter int TILE_COLS    = 16,
    parameter int K_SLICES     = 4,
    parameter int PSUM_W       = 16,
    parameter int ACC_W        = 24,
    parameter int SPIKE_THRESH = 256
) (
    input  logic                     s_clk,
    input  logic                     s_rst,
    input  logic                     i_tile_start,
    input  logic                     psum_valid,
    input  logic signed [PSUM_W-1:0] psum_data,
    output logic                     psum_ready,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     o_busy,
    output logic                     o_tile_done
);

    localparam int TILE_ELEMS = TILE_ROWS * TILE_COLS;
    localparam int IDX_W      = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;
    localparam int SLICE_W    = (K_SLICES > 1) ? $clog2(K_SLICES) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(TILE_ELEMS - 1);
    localparam logic [SLICE_W-1:0]      LAST_SLICE = SLICE_W'(K_SLICES - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]               state;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         rdIdx;
    logic [SLICE_W-1:0]       slice;
    logic signed [ACC_W-1:0]  tileBuf [TILE_ELEMS];

    logic                     accept;
    logic                     outFire;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  satSum;
    logic signed [ACC_W-1:0]  rdVal;
    logic [ACC_W:0]           rawSum;

    assign psum_ready = (state == ACCUM);
    assign out_valid  = (state == DRAIN);
    assign o_busy     = (state != IDLE);
    assign accept     = psum_ready && psum_valid;
    assign outFire    = out_valid && out_ready;
    assign out_last   = out_valid && (rdIdx == LAST_IDX);
    assign rdVal      = tileBuf[rdIdx];

    // Read-modify-write datapath: first slice starts from zero, later slices
    // add onto the buffered value; one extra bit detects overflow for clamping.
    always_comb begin
        base   = (slice == '0) ? '0 : tileBuf[idx];
        rawSum = {base[ACC_W-1], base}
               + {{(ACC_W+1-PSUM_W){psum_data[PSUM_W-1]}}, psum_data};
        if (rawSum[ACC_W] != rawSum[ACC_W-1]) begin
            satSum = rawSum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            satSum = rawSum[ACC_W-1:0];
        end
    end

    // Output element formatting; forced to zero outside DRAIN
`ifdef PSUM_SPIKE_EN
    localparam logic signed [ACC_W-1:0] THRESH = ACC_W'(SPIKE_THRESH);
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = {{(ACC_W-1){1'b0}}, (rdVal >= THRESH)};
        end
    end
`else
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = rdVal;
        end
    end
`endif

    // Tile buffer write; contents need no reset since slice 0 never reads them
    always_ff @(posedge s_clk) begin
        if (accept) begin
            tileBuf[idx] <= satSum;
        end
    end

    // Sequencing FSM with write/read position counters and done pulse
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state       <= IDLE;
            idx         <= '0;
            slice       <= '0;
            rdIdx       <= '0;
            o_tile_done <= 1'b0;
        end else begin
            o_tile_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_tile_start) begin
                        state <= ACCUM;
                        idx   <= '0;
                        slice <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (slice == LAST_SLICE) begin
                                state <= DRAIN;
                                slice <= '0;
                                rdIdx <= '0;
                            end else begin
                                slice <= slice + SLICE_W'(1);
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (outFire) begin
                        if (out_last) begin
                            state       <= IDLE;
                            rdIdx       <= '0;
                            o_tile_done <= 1'b1;
                        end else begin
                            rdIdx <= rdIdx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_psum_accumulator.sv
// Testbench for mm_psum_accumulator. Two instances share all inputs: one with
// ACC_W=10 and one with ACC_W=8 (saturation-sensitive). Expected results come
// from a per-element running sum with clamping, computed from the stimulus.
module tb_mm_psum_accumulator;

    localparam int E   = 4;
    localparam int K   = 2;
    localparam int PW  = 8;
    localparam int WA  = 10;
    localparam int WB  = 8;
    localparam int THR = 30;

    logic                 s_clk;
    logic                 s_rst;
    logic                 i_tile_start;
    logic                 psum_valid;
    logic signed [PW-1:0] psum_data;
    logic                 out_ready;

    logic                 readyA, validA, lastA, busyA, doneA;
    logic signed [WA-1:0] dataA;
    logic                 readyB, validB, lastB, busyB, doneB;
    logic signed [WB-1:0] dataB;

    int stim [K][E];
    int expA [E];
    int expB [E];
    int errors;
    int checks;

    mm_psum_accumulator #(
        .TILE_ROWS(2), .TILE_COLS(2), .K_SLICES(K), .PSUM_W(PW),
        .ACC_W(WA), .SPIKE_THRESH(THR)
    ) dutA (
        .s_clk(s_clk), .s_rst(s_rst), .i_tile_start(i_tile_start),
        .psum_valid(psum_valid), .psum_data(psum_data), .psum_ready(readyA),
        .out_valid(validA), .out_data(dataA), .out_last(lastA),
        .out_ready(out_ready), .o_busy(busyA), .o_tile_done(doneA)
    );

    mm_psum_accumulator #(
        .TILE_ROWS(2), .TILE_COLS(2), .K_SLICES(K), .PSUM_W(PW),
        .ACC_W(WB), .SPIKE_THRESH(THR)
    ) dutB (
        .s_clk(s_clk), .s_rst(s_rst), .i_tile_start(i_tile_start),
        .psum_valid(psum_valid), .psum_data(psum_data), .psum_ready(readyB),
        .out_valid(validB), .out_data(dataB), .out_last(lastB),
        .out_ready(out_ready), .o_busy(busyB), .o_tile_done(doneB)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    function automatic int satW(input int v, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int toOut(input int v);
`ifdef PSUM_SPIKE_EN
        return (v >= THR) ? 1 : 0;
`else
        return v;
`endif
    endfunction

    task automatic computeExp();
        for (int e = 0; e < E; e++) begin
            int a, b;
            a = 0;
            b = 0;
            for (int s = 0; s < K; s++) begin
                a = satW(a + stim[s][e], WA);
                b = satW(b + stim[s][e], WB);
            end
            expA[e] = toOut(a);
            expB[e] = toOut(b);
        end
    endtask

    task automatic randomStim();
        for (int s = 0; s < K; s++)
            for (int e = 0; e < E; e++)
                stim[s][e] = int'($urandom_range(255)) - 128;
        computeExp();
    endtask

    task automatic basicStim();
        for (int e = 0; e < E; e++) begin
            stim[0][e] = e + 1;
            stim[1][e] = 10 * (e + 1);
        end
        computeExp();
    endtask

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    // Feeds one tile of psums; optional random valid gaps and a stray start pulse
    task automatic sendTile(input int gapPct, input bit midStart, input bit doStart);
        int n;
        int budget;
        bit acc;
        if (doStart) begin
            i_tile_start = 1'b1;
            step();
            i_tile_start = 1'b0;
            checks++;
            if (readyA !== 1'b1 || readyB !== 1'b1 || busyA !== 1'b1 || busyB !== 1'b1) begin
                errors++;
                $display("FAIL start_ready: ready=%b/%b busy=%b/%b expected 1", readyA, readyB, busyA, busyB);
            end
        end
        n = 0;
        budget = 0;
        while (n < K * E && budget < 400) begin
            if (gapPct > 0 && int'($urandom_range(99)) < gapPct) begin
                psum_valid = 1'b0;
                psum_data  = PW'($urandom);
            end else begin
                psum_valid = 1'b1;
                psum_data  = PW'(stim[n / E][n % E]);
            end
            i_tile_start = (midStart && n == 3);
            acc = psum_valid && readyA;
            step();
            if (acc) n++;
            budget++;
        end
        psum_valid   = 1'b0;
        i_tile_start = 1'b0;
        checks++;
        if (n != K * E) begin
            errors++;
            $display("FAIL accum_timeout: accepted %0d expected %0d", n, K * E);
        end
        checks++;
        if (validA !== 1'b1 || dataA !== expA[0] || dataB !== expB[0]) begin
            errors++;
            $display("FAIL first_out: valid=%b data=%0d/%0d expected 1 %0d/%0d", validA, dataA, dataB, expA[0], expB[0]);
        end
    endtask

    // Drains one tile. mode 0: always ready, 1: stall 5 cycles on element 2, 2: random ready
    task automatic collectTile(input int mode, input bit startNext);
        int k, cyc, stall;
        bit r;
        k = 0;
        cyc = 0;
        stall = 0;
        while (k < E && cyc < 200) begin
            case (mode)
                0: r = 1'b1;
                1: begin
                    if (k == 2 && stall < 5) begin r = 1'b0; stall++; end
                    else r = 1'b1;
                end
                default: r = 1'($urandom_range(1));
            endcase
            out_ready = r;
            checks++;
            if (validA !== 1'b1 || validB !== 1'b1) begin
                errors++;
                $display("FAIL out_valid[%0d]: got %b/%b expected 1", k, validA, validB);
            end
            checks++;
            if (dataA !== expA[k] || dataB !== expB[k]) begin
                errors++;
                $display("FAIL out_data[%0d]: got %0d/%0d expected %0d/%0d", k, dataA, dataB, expA[k], expB[k]);
            end
            checks++;
            if (lastA !== (k == E - 1) || lastB !== (k == E - 1)) begin
                errors++;
                $display("FAIL out_last[%0d]: got %b/%b expected %b", k, lastA, lastB, (k == E - 1));
            end
            step();
            if (r) k++;
            cyc++;
        end
        out_ready = 1'b0;
        if (mode == 0) begin
            checks++;
            if (cyc != E) begin
                errors++;
                $display("FAIL drain_cycles: got %0d expected %0d", cyc, E);
            end
        end
        checks++;
        if (doneA !== 1'b1 || doneB !== 1'b1 || busyA !== 1'b0 || validA !== 1'b0) begin
            errors++;
            $display("FAIL tile_done: done=%b/%b busy=%b valid=%b expected 1/1 0 0", doneA, doneB, busyA, validA);
        end
        if (startNext) i_tile_start = 1'b1;
        step();
        i_tile_start = 1'b0;
        checks++;
        if (doneA !== 1'b0 || doneB !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: got %b/%b expected 0", doneA, doneB);
        end
        if (startNext) begin
            checks++;
            if (readyA !== 1'b1 || readyB !== 1'b1) begin
                errors++;
                $display("FAIL restart_ready: got %b/%b expected 1", readyA, readyB);
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checks++;
        if (readyA !== 1'b0 || validA !== 1'b0 || dataA !== '0 || lastA !== 1'b0 ||
            busyA !== 1'b0 || doneA !== 1'b0 || readyB !== 1'b0 || validB !== 1'b0 ||
            dataB !== '0 || lastB !== 1'b0 || busyB !== 1'b0 || doneB !== 1'b0) begin
            errors++;
            $display("FAIL %s: ready=%b valid=%b data=%0d last=%b busy=%b done=%b expected all 0",
                     tag, readyA, validA, dataA, lastA, busyA, doneA);
        end
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        i_tile_start = 1'b0;
        psum_valid = 1'b0;
        psum_data = '0;
        out_ready = 1'b0;
        repeat (2) step();
        checkResetOutputs("reset_values");
        s_rst = 1'b0;
        step();
        checkResetOutputs("post_reset_idle");
    endtask

    task automatic test_basic();
        basicStim();
        sendTile(0, 1'b0, 1'b1);
        collectTile(0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int e = 0; e < E; e++) begin
            stim[0][e] = 127;
            stim[1][e] = 127;
        end
        computeExp();
        sendTile(0, 1'b0, 1'b1);
        collectTile(0, 1'b0);
        for (int e = 0; e < E; e++) begin
            stim[0][e] = -128;
            stim[1][e] = -128;
        end
        computeExp();
        sendTile(0, 1'b0, 1'b1);
        collectTile(0, 1'b0);
    endtask

    task automatic test_gaps();
        basicStim();
        sendTile(40, 1'b0, 1'b1);
        collectTile(2, 1'b0);
    endtask

    task automatic test_backpressure();
        basicStim();
        sendTile(0, 1'b0, 1'b1);
        collectTile(1, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        psum_valid = 1'b1;
        psum_data = PW'(99);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (readyA !== 1'b0 || readyB !== 1'b0 || validA !== 1'b0 || busyA !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore: ready=%b/%b valid=%b busy=%b expected 0", readyA, readyB, validA, busyA);
            end
        end
        psum_valid = 1'b0;
        basicStim();
        sendTile(0, 1'b1, 1'b1);
        collectTile(0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n;
        randomStim();
        i_tile_start = 1'b1;
        step();
        i_tile_start = 1'b0;
        n = 0;
        while (n < 5) begin
            psum_valid = 1'b1;
            psum_data = PW'(stim[n / E][n % E]);
            step();
            n++;
        end
        psum_valid = 1'b0;
        s_rst = 1'b1;
        #1;
        checkResetOutputs("reset_mid_accum");
        step();
        s_rst = 1'b0;
        step();
        checkResetOutputs("after_reset_accum");
        randomStim();
        sendTile(0, 1'b0, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        s_rst = 1'b1;
        #1;
        checkResetOutputs("reset_mid_drain");
        step();
        s_rst = 1'b0;
        step();
        checkResetOutputs("after_reset_drain");
        randomStim();
        sendTile(20, 1'b0, 1'b1);
        collectTile(0, 1'b0);
    endtask

    task automatic test_back_to_back();
        randomStim();
        sendTile(0, 1'b0, 1'b1);
        for (int t = 0; t < 3; t++) begin
            collectTile(0, 1'b1);
            randomStim();
            sendTile(0, 1'b0, 1'b0);
        end
        collectTile(0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            randomStim();
            sendTile(30, (t % 3) == 0, 1'b1);
            collectTile(2, 1'b0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_gaps();
        test_backpressure();
        test_ignored_inputs();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mm_psum_accumulator.md
# mm_psum_accumulator

- Sits directly downstream of `SystolicArray`, one instance per output tile.
- Consumes the partial-sum elements produced for each K-slice of a matrix-multiply tile.
- Accumulates them element-wise across all K-slices in a local tile buffer, then streams the finished tile to the next stage.
- Gives the spiking-transformer datapath a single, saturated result per output element.

## Interface
Parameters:
- `TILE_ROWS`, 16, rows per output tile
- `TILE_COLS`, 16, columns per output tile; `TILE_ELEMS = TILE_ROWS*TILE_COLS`
- `K_SLICES`, 4, number of partial-sum passes per tile (≥1)
- `PSUM_W`, 16, signed width of one incoming partial sum
- `ACC_W`, 24, signed accumulator/output width (`ACC_W ≥ PSUM_W`)
- `SPIKE_THRESH`, 256, signed firing threshold (used only with `PSUM_SPIKE_EN`)

Ports (one clock; reset is asynchronous and active-high):
- `s_clk` in 1: clock
- `s_rst` in 1: asynchronous active-high reset
- `i_tile_start` in 1: one-cycle pulse that starts a new tile
- `psum_valid` in 1: partial-sum element valid
- `psum_data` in `PSUM_W`: signed partial sum, row-major element order
- `psum_ready` out 1: element accepted when `psum_valid && psum_ready`
- `out_valid` out 1: finished element valid
- `out_data` out `ACC_W`: accumulated (or spike) value
- `out_last` out 1: marks the final element of the tile
- `out_ready` in 1: downstream accept
- `o_busy` out 1: high whenever state ≠ IDLE
- `o_tile_done` out 1: one-cycle pulse after the final output handshake

## Operation
States: IDLE → ACCUM → DRAIN → IDLE.

- **IDLE**
  - `psum_ready=0`, `out_valid=0`.
  - `i_tile_start` → ACCUM; `idx=0`, `slice=0`.
- **ACCUM**
  - `psum_ready=1`. `buf` holds `TILE_ELEMS` entries of `ACC_W` bits.
  - Each accepted element: `buf[idx] = sat(base + sext(psum_data))`, where `base = 0` if `slice==0`, else `buf[idx]`.
  - `idx` increments per acceptance. When `idx==TILE_ELEMS-1`, `idx` wraps to 0 and `slice` increments.
  - Acceptance at `idx==TILE_ELEMS-1` with `slice==K_SLICES-1` → DRAIN; `rd_idx=0`.
- **DRAIN**
  - `out_valid=1`, `out_data=f(buf[rd_idx])`, `out_last=(rd_idx==TILE_ELEMS-1)`.
  - `rd_idx` increments on each `out_valid && out_ready`.
  - Handshake with `out_last=1` → IDLE; `o_tile_done` pulses high the following cycle.
- Saturation `sat()`: clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. There is no wrap-around on overflow.
- `i_tile_start` outside IDLE is ignored; it never restarts a tile in flight.
- `psum_valid` in IDLE or DRAIN is not accepted, and the data is not consumed.
- Upstream may deassert `psum_valid` at any cycle; the accumulation position holds.

## Timing
- Reset values: `psum_ready=0`, `out_valid=0`, `out_data=0`, `out_last=0`, `o_busy=0`, `o_tile_done=0`. State is IDLE, counters are 0, buffer contents are don't-care.
- Reset asserted mid-ACCUM or mid-DRAIN aborts the tile immediately; no `o_tile_done`.
- `i_tile_start` sampled at edge N → `psum_ready=1` from cycle N+1.
- Throughput in ACCUM is one element per cycle. The read-modify-write completes in the accepting cycle (combinational buffer read, registered write).
- Last psum accepted at edge N → `out_valid=1` in cycle N+1, with `out_data=buf[0]` already reflecting the final write.
- Drain takes exactly `TILE_ELEMS` cycles with `out_ready` held high.
- `out_data` and `out_last` are stable while `out_valid && !out_ready`.
- Final handshake at edge M → `o_busy=0`, `o_tile_done=1` in cycle M+1. A new `i_tile_start` is accepted in that same cycle.

## Configuration
- `PSUM_SPIKE_EN` defined:
  - `out_data = {ACC_W-1'b0, (buf[rd_idx] >= SPIKE_THRESH)}`, a signed compare.
  - Accumulation is unchanged.
- `PSUM_SPIKE_EN` undefined: `out_data = buf[rd_idx]`, the full saturated sum.

## Test plan
Params `TILE_ROWS=2`, `TILE_COLS=2`, `K_SLICES=2`, `PSUM_W=8`, `ACC_W=10` unless noted.

- **Basic accumulate.** Start, then psums 1,2,3,4 followed by 10,20,30,40 back-to-back, `out_ready=1` → outputs 11,22,33,44. `out_last` high on 44. `o_tile_done` pulses one cycle after.
- **Saturation.** Psums 127×4 then 127×4, with `ACC_W=8` → all outputs 127. Psums −128 then −128 → −128.
- **Backpressure and gaps.**
  - Random `psum_valid` gaps produce the same results as the basic-accumulate case.
  - With `out_ready` low for 5 cycles on element 2, `out_data` holds 33 and no element is lost.
- **Ignored inputs.**
  - `i_tile_start` pulsed mid-ACCUM leaves results unchanged.
  - `psum_valid=1` in IDLE keeps `psum_ready=0` and accepts nothing.
- **Reset mid-operation.** Assert `s_rst` after 5 accepted psums → all outputs at reset values. A fresh tile then gives the correct sums with no carry-over.
- **Spike mode.** With `PSUM_SPIKE_EN`, `SPIKE_THRESH=30`, and the basic-accumulate stimulus → outputs 0,0,1,1.
